// File: rtl/logic_op_sequencer_if.sv
// Request/result bundle for the bit-serial logic sequencer.
// The master drives the operands and start; the slave returns busy, done and the result.
interface logic_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] w;

    modport master (
        output start, op, x, y,
        input  busy, done, w
    );

    modport slave (
        input  start, op, x, y,
        output busy, done, w
    );
endinterface

// File: rtl/logic_op_sequencer.sv
// Bit-serial logic-op sequencer: one operand bit pair per clock, LSB first, through a single 1-bit unit.
// Latency WIDTH+1 cycles from accepted start to done; start is only sampled in IDLE or DONE.
module logic_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    logic_op_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             finish;

    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [2:0]       opr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] w_q;
    logic             busy_q;
    logic             done_q;
    logic             res_bit;
    logic             cnt_last;

    assign cnt_last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_last) begin
                    state_nxt = DONE;
                    finish    = 1'b1;
                end
            end
            DONE: begin
                // A start in the DONE cycle chains straight into the next op.
                if (bus.start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The shared 1-bit logic unit, fed from the LSB of the shifting operand copies.
    always_comb begin
        res_bit = 1'b0;
        unique case (opr)
            3'b000: res_bit = ~xr[0];
            3'b001: res_bit = xr[0] & yr[0];
            3'b010: res_bit = ~(xr[0] & yr[0]);
            3'b011: res_bit = xr[0] ^ yr[0];
            3'b100: res_bit = ~(xr[0] ^ yr[0]);
            3'b101: res_bit = xr[0] | yr[0];
            3'b110: res_bit = ~(xr[0] | yr[0]);
            3'b111: res_bit = 1'b0;
            default: res_bit = 1'b0;
        endcase
    end

    // New bits enter at the MSB so that after WIDTH shifts bit i lands at position i.
    generate
        if (WIDTH == 1) begin : g_sr1
            assign sr_next = res_bit;
        end else begin : g_srn
            assign sr_next = {res_bit, sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xr     <= '0;
            yr     <= '0;
            opr    <= '0;
            cnt    <= '0;
            sr     <= '0;
            w_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (load) begin
                xr  <= bus.x;
                yr  <= bus.y;
                opr <= bus.op;
                cnt <= '0;
                sr  <= '0;
            end else if (step) begin
                xr  <= xr >> 1;
                yr  <= yr >> 1;
                cnt <= cnt + CW'(1);
                sr  <= sr_next;
            end
            if (finish) begin
                w_q <= sr_next;
            end
            busy_q <= (state_nxt == RUN);
            done_q <= (state_nxt == DONE);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.w    = w_q;
endmodule

// File: tb/tb_logic_op_sequencer.sv
// Self-checking bench for logic_op_sequencer: vector table plus scoreboard on done pulses.
module tb_logic_op_sequencer;
    logic clk;
    logic reset;

    logic_op_sequencer_if #(.WIDTH(8)) bus8 ();
    logic_op_sequencer_if #(.WIDTH(1)) bus1 ();

    logic_op_sequencer #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    logic_op_sequencer #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];
    logic [7:0] prev_w;

    typedef struct {
        logic [2:0] op;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            3'd0: return ~a;
            3'd1: return a & b;
            3'd2: return ~(a & b);
            3'd3: return a ^ b;
            3'd4: return ~(a ^ b);
            3'd5: return a | b;
            3'd6: return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int nbusy, output bit ok);
        nbusy = 0;
        ok    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus8.done) begin
                ok = 1'b1;
                return;
            end
            if (bus8.busy) nbusy++;
            tick();
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
        int nb;
        bit ok;
        bus8.op    = o;
        bus8.x     = a;
        bus8.y     = b;
        bus8.start = 1'b1;
        sb.push_back(e);
        tick();
        bus8.start = 1'b0;
        wait_done(nb, ok);
        chk("done_timeout", ok, 1);
        chk("busy_cycles", nb, 8);
        tick();
    endtask

    // Scoreboard and invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy_done_exclusive", bus8.busy & bus8.done, 0);
            if (bus8.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("w_result", bus8.w, sb.pop_front());
                end
            end else if (bus8.w !== prev_w) begin
                chk("w_changed_without_done", bus8.w, prev_w);
            end
        end
        prev_w = bus8.w;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        bit ok;
        bit seen;

        vecs[0] = '{3'b001, 8'hF0, 8'h3C, 8'h30};
        vecs[1] = '{3'b000, 8'hCA, 8'h5C, 8'h35};
        vecs[2] = '{3'b001, 8'hCA, 8'h5C, 8'h48};
        vecs[3] = '{3'b010, 8'hCA, 8'h5C, 8'hB7};
        vecs[4] = '{3'b011, 8'hCA, 8'h5C, 8'h96};
        vecs[5] = '{3'b100, 8'hCA, 8'h5C, 8'h69};
        vecs[6] = '{3'b101, 8'hCA, 8'h5C, 8'hDE};
        vecs[7] = '{3'b110, 8'hCA, 8'h5C, 8'h21};
        vecs[8] = '{3'b111, 8'hCA, 8'h5C, 8'h00};

        reset      = 1'b1;
        bus8.start = 1'b0;
        bus8.op    = '0;
        bus8.x     = '0;
        bus8.y     = '0;
        bus1.start = 1'b0;
        bus1.op    = '0;
        bus1.x     = '0;
        bus1.y     = '0;
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            chk("idle_w", bus8.w, 8'h00);
            chk("idle_busy", bus8.busy, 0);
            chk("idle_done", bus8.done, 0);
            tick();
        end

        // Basic AND plus full op sweep.
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].exp);
        end

        // Inputs scrambled and start held during RUN, then a chained op from DONE.
        bus8.op    = 3'b001;
        bus8.x     = 8'hF0;
        bus8.y     = 8'h3C;
        bus8.start = 1'b1;
        sb.push_back(8'h30);
        tick();
        nb = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus8.done) begin
                ok = 1'b1;
                break;
            end
            if (bus8.busy) nb++;
            bus8.x  = 8'($urandom);
            bus8.y  = 8'($urandom);
            bus8.op = 3'($urandom_range(0, 7));
            tick();
        end
        chk("held_start_timeout", ok, 1);
        chk("held_start_busy_cycles", nb, 8);
        bus8.op = 3'b011;
        bus8.x  = 8'hAA;
        bus8.y  = 8'h0F;
        sb.push_back(model(3'b011, 8'hAA, 8'h0F));
        tick();
        bus8.start = 1'b0;
        chk("b2b_busy", bus8.busy, 1);
        chk("b2b_done", bus8.done, 0);
        wait_done(nb, ok);
        chk("b2b_timeout", ok, 1);
        chk("b2b_busy_cycles", nb, 8);
        tick();

        // Reset in the middle of RUN aborts without a done pulse.
        bus8.op    = 3'b010;
        bus8.x     = 8'hCA;
        bus8.y     = 8'h5C;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (4) tick();
        chk("pre_abort_busy", bus8.busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", bus8.busy, 0);
        chk("abort_done", bus8.done, 0);
        chk("abort_w", bus8.w, 8'h00);
        tick();
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done || bus8.busy) seen = 1'b1;
            tick();
        end
        chk("no_activity_after_abort", seen, 0);
        issue(3'b101, 8'hCA, 8'h5C, model(3'b101, 8'hCA, 8'h5C));
        issue(3'b100, 8'h0F, 8'h33, model(3'b100, 8'h0F, 8'h33));

        // Reset coincident with start: the request is dropped.
        reset      = 1'b1;
        bus8.op    = 3'b001;
        bus8.start = 1'b1;
        tick();
        reset      = 1'b0;
        bus8.start = 1'b0;
        tick();
        chk("reset_wins_busy", bus8.busy, 0);
        chk("reset_wins_w", bus8.w, 8'h00);

        // Single-bit instance.
        bus1.op    = 3'b011;
        bus1.x     = 1'b1;
        bus1.y     = 1'b0;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        chk("w1_busy", bus1.busy, 1);
        chk("w1_done_early", bus1.done, 0);
        tick();
        chk("w1_busy_after", bus1.busy, 0);
        chk("w1_done", bus1.done, 1);
        chk("w1_w", bus1.w, 1);
        tick();
        chk("w1_done_pulse", bus1.done, 0);

        repeat (3) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
